// File: rtl/midori_pkg.sv
// Shared constants, FSM encoding and column mixing for the masked Midori64 round controller.
package midori_pkg;

    localparam int unsigned BLOCK_W    = 64;
    localparam int unsigned KEY_W      = 128;
    localparam int unsigned CELL_W     = 4;
    localparam int unsigned COL_W      = 16;
    localparam int unsigned NUM_CELLS  = 16;
    localparam int unsigned NUM_SHARES = 3;
    localparam int unsigned RND_W      = 4;

    localparam logic [RND_W-1:0] LAST_RND = 4'd15;

    // Round constants; bit b lands on the LSB of nibble b (bits [4b+3:4b]).
    localparam logic [15:0] BETA [0:14] = '{
        16'h15b3, 16'h78c0, 16'ha435, 16'h6213, 16'h104f,
        16'hd170, 16'h0266, 16'h0bcc, 16'h9481, 16'h40b8,
        16'h7197, 16'h228e, 16'h5130, 16'hf8ca, 16'hdf90
    };

    // Cell i (cell 0 = most significant nibble) takes old cell SHUFFLE[i].
    localparam logic [3:0] SHUFFLE [0:15] = '{
        4'd0, 4'd10, 4'd5, 4'd15, 4'd14, 4'd4, 4'd11, 4'd1,
        4'd9, 4'd3, 4'd12, 4'd6, 4'd7, 4'd13, 4'd2, 4'd8
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SBOX = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Almost-MDS column mix: every cell becomes the XOR of the other three.
    function automatic logic [COL_W-1:0] mix_column(input logic [COL_W-1:0] col);
        logic [CELL_W-1:0] c0, c1, c2, c3;
        {c0, c1, c2, c3} = col;
        return {c1 ^ c2 ^ c3, c0 ^ c2 ^ c3, c0 ^ c1 ^ c3, c0 ^ c1 ^ c2};
    endfunction

    // Expand the 16-bit round constant of round rnd onto the 64-bit state.
    function automatic logic [BLOCK_W-1:0] round_const(input logic [RND_W-1:0] rnd);
        logic [15:0]        b;
        logic [BLOCK_W-1:0] m;
        b = (rnd == LAST_RND) ? 16'h0000 : BETA[rnd];
        m = '0;
        for (int i = 0; i < 16; i++) begin
            m[CELL_W*i] = b[i];
        end
        return m;
    endfunction

endpackage

// File: rtl/midori_round_ctrl_lin.sv
// Share-local Midori64 linear layer: ShuffleCell followed by MixColumn.
module midori_lin_layer
    import midori_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_i,
    output logic [BLOCK_W-1:0] state_c_o
);

    logic [BLOCK_W-1:0] shuf;

    // Cell permutation, pure wiring.
    for (genvar c = 0; c < NUM_CELLS; c++) begin : g_shuffle
        localparam int unsigned SRC = 32'(SHUFFLE[c]);
        assign shuf[BLOCK_W-1-CELL_W*c -: CELL_W] = state_i[BLOCK_W-1-CELL_W*SRC -: CELL_W];
    end

    // Four independent column mixes.
    for (genvar j = 0; j < BLOCK_W / COL_W; j++) begin : g_mix
        assign state_c_o[BLOCK_W-1-COL_W*j -: COL_W] = mix_column(shuf[BLOCK_W-1-COL_W*j -: COL_W]);
    end

endmodule

// File: rtl/midori_round_ctrl.sv
// Round datapath and sequencer for the 3-share masked Midori64 core; drives and consumes the S-box array.
module midori_round_ctrl
    import midori_pkg::*;
#(
    parameter int unsigned SBOX_LAT = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [BLOCK_W-1:0] pt_s0_i,
    input  logic [BLOCK_W-1:0] pt_s1_i,
    input  logic [BLOCK_W-1:0] pt_s2_i,
    input  logic [KEY_W-1:0]   key_s0_i,
    input  logic [KEY_W-1:0]   key_s1_i,
    input  logic [KEY_W-1:0]   key_s2_i,
    output logic [BLOCK_W-1:0] sbox_in_s0_o,
    output logic [BLOCK_W-1:0] sbox_in_s1_o,
    output logic [BLOCK_W-1:0] sbox_in_s2_o,
    input  logic [BLOCK_W-1:0] sbox_out_s0_i,
    input  logic [BLOCK_W-1:0] sbox_out_s1_i,
    input  logic [BLOCK_W-1:0] sbox_out_s2_i,
    output logic               sbox_act_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [BLOCK_W-1:0] ct_s0_o,
    output logic [BLOCK_W-1:0] ct_s1_o,
    output logic [BLOCK_W-1:0] ct_s2_o
);

    localparam int unsigned      CNT_W    = $clog2(SBOX_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SBOX_LAT);

    state_e             fsm_q, fsm_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               act_q, act_d;
    logic               done_q, done_d;
    logic [BLOCK_W-1:0] state_q [NUM_SHARES];
    logic [BLOCK_W-1:0] state_d [NUM_SHARES];
    logic [BLOCK_W-1:0] ct_q    [NUM_SHARES];
    logic [BLOCK_W-1:0] ct_d    [NUM_SHARES];

    logic [BLOCK_W-1:0] pt  [NUM_SHARES];
    logic [KEY_W-1:0]   key [NUM_SHARES];
    logic [BLOCK_W-1:0] sbo [NUM_SHARES];
    logic [BLOCK_W-1:0] lin [NUM_SHARES];
    logic [BLOCK_W-1:0] wk  [NUM_SHARES];
    logic [BLOCK_W-1:0] rk  [NUM_SHARES];

    assign pt[0]  = pt_s0_i;
    assign pt[1]  = pt_s1_i;
    assign pt[2]  = pt_s2_i;
    assign key[0] = key_s0_i;
    assign key[1] = key_s1_i;
    assign key[2] = key_s2_i;
    assign sbo[0] = sbox_out_s0_i;
    assign sbo[1] = sbox_out_s1_i;
    assign sbo[2] = sbox_out_s2_i;

    // One linear layer per share; shares never mix.
    for (genvar s = 0; s < NUM_SHARES; s++) begin : g_lin
        midori_lin_layer u_lin (
            .state_i   (sbo[s]),
            .state_c_o (lin[s])
        );
    end

    // Whitening key and round-key select; even rounds use key[127:64], odd rounds key[63:0]; constant on share 0 only.
    always_comb begin
        for (int s = 0; s < NUM_SHARES; s++) begin
            wk[s] = key[s][KEY_W-1:BLOCK_W] ^ key[s][BLOCK_W-1:0];
            rk[s] = rnd_q[0] ? key[s][BLOCK_W-1:0] : key[s][KEY_W-1:BLOCK_W];
        end
        rk[0] = rk[0] ^ round_const(rnd_q);
    end

    // Next-state, datapath updates and registered status flags.
    always_comb begin
        fsm_d  = fsm_q;
        rnd_d  = rnd_q;
        cnt_d  = cnt_q;
        busy_d = 1'b0;
        act_d  = 1'b0;
        done_d = 1'b0;
        for (int s = 0; s < NUM_SHARES; s++) begin
            state_d[s] = state_q[s];
            ct_d[s]    = ct_q[s];
        end

        case (fsm_q)
            ST_IDLE: begin
                if (start_i) begin
                    fsm_d = ST_SBOX;
                    rnd_d = '0;
                    cnt_d = '0;
                    for (int s = 0; s < NUM_SHARES; s++) begin
                        state_d[s] = pt[s] ^ wk[s];
                    end
                end
            end
            ST_SBOX: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rnd_q == LAST_RND) begin
                        fsm_d = ST_DONE;
                        for (int s = 0; s < NUM_SHARES; s++) begin
                            ct_d[s] = sbo[s] ^ wk[s];
                        end
                    end else begin
                        rnd_d = rnd_q + RND_W'(1);
                        for (int s = 0; s < NUM_SHARES; s++) begin
                            state_d[s] = lin[s] ^ rk[s];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase

        busy_d = (fsm_d == ST_SBOX);
        act_d  = (fsm_d == ST_SBOX);
        done_d = (fsm_d == ST_DONE);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q  <= ST_IDLE;
            rnd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            act_q  <= 1'b0;
            done_q <= 1'b0;
            for (int s = 0; s < NUM_SHARES; s++) begin
                state_q[s] <= '0;
                ct_q[s]    <= '0;
            end
        end else begin
            fsm_q  <= fsm_d;
            rnd_q  <= rnd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            act_q  <= act_d;
            done_q <= done_d;
            for (int s = 0; s < NUM_SHARES; s++) begin
                state_q[s] <= state_d[s];
                ct_q[s]    <= ct_d[s];
            end
        end
    end

    assign sbox_in_s0_o = state_q[0];
    assign sbox_in_s1_o = state_q[1];
    assign sbox_in_s2_o = state_q[2];
    assign ct_s0_o      = ct_q[0];
    assign ct_s1_o      = ct_q[1];
    assign ct_s2_o      = ct_q[2];
    assign sbox_act_o   = act_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_midori_round_ctrl.sv
// Bench for midori_round_ctrl: behavioural masked S-box arrays (latency 4 and 2) and a cell-level Midori64 model.
module tb_midori_round_ctrl;

    localparam logic [3:0] SBX [16] = '{
        4'hc, 4'ha, 4'hd, 4'h3, 4'he, 4'hb, 4'hf, 4'h7,
        4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
    };
    localparam int PERM [16] = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};
    localparam logic [15:0] BETA_T [15] = '{
        16'h15b3, 16'h78c0, 16'ha435, 16'h6213, 16'h104f,
        16'hd170, 16'h0266, 16'h0bcc, 16'h9481, 16'h40b8,
        16'h7197, 16'h228e, 16'h5130, 16'hf8ca, 16'hdf90
    };
    localparam logic [63:0]  CT_ZERO = 64'h3c9cceda2bbd449a;
    localparam logic [127:0] TV_KEY  = 128'h687ded3b3c85b3f35b1009863e2a8cbf;
    localparam logic [63:0]  TV_PT   = 64'h42c20fd3b586879e;
    localparam logic [63:0]  TV_CT   = 64'h66bcdc6270d901cd;
    localparam int LAT4 = 81;
    localparam int LAT2 = 49;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         sel2  = 1'b0;
    logic [63:0]  pt_s0 = '0, pt_s1 = '0, pt_s2 = '0;
    logic [127:0] key_s0 = '0, key_s1 = '0, key_s2 = '0;
    int           nvec = 0;
    int           nmis = 0;

    logic        start4, start2;
    logic [63:0] sin4_0, sin4_1, sin4_2, sout4_0, sout4_1, sout4_2, ct4_0, ct4_1, ct4_2;
    logic [63:0] sin2_0, sin2_1, sin2_2, sout2_0, sout2_1, sout2_2, ct2_0, ct2_1, ct2_2;
    logic        act4, busy4, done4, act2, busy2, done2;

    always #5 clk = ~clk;

    assign start4 = start & ~sel2;
    assign start2 = start & sel2;

    midori_round_ctrl #(.SBOX_LAT(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4),
        .pt_s0_i(pt_s0), .pt_s1_i(pt_s1), .pt_s2_i(pt_s2),
        .key_s0_i(key_s0), .key_s1_i(key_s1), .key_s2_i(key_s2),
        .sbox_in_s0_o(sin4_0), .sbox_in_s1_o(sin4_1), .sbox_in_s2_o(sin4_2),
        .sbox_out_s0_i(sout4_0), .sbox_out_s1_i(sout4_1), .sbox_out_s2_i(sout4_2),
        .sbox_act_o(act4), .busy_o(busy4), .done_o(done4),
        .ct_s0_o(ct4_0), .ct_s1_o(ct4_1), .ct_s2_o(ct4_2)
    );

    midori_round_ctrl #(.SBOX_LAT(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2),
        .pt_s0_i(pt_s0), .pt_s1_i(pt_s1), .pt_s2_i(pt_s2),
        .key_s0_i(key_s0), .key_s1_i(key_s1), .key_s2_i(key_s2),
        .sbox_in_s0_o(sin2_0), .sbox_in_s1_o(sin2_1), .sbox_in_s2_o(sin2_2),
        .sbox_out_s0_i(sout2_0), .sbox_out_s1_i(sout2_1), .sbox_out_s2_i(sout2_2),
        .sbox_act_o(act2), .busy_o(busy2), .done_o(done2),
        .ct_s0_o(ct2_0), .ct_s1_o(ct2_1), .ct_s2_o(ct2_2)
    );

    // S-box array model: unmask, substitute, re-share with fresh masks, delay by the latency.
    function automatic logic [63:0] sb_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = SBX[x[4*i +: 4]];
        return y;
    endfunction

    function automatic logic [191:0] remask(input logic [63:0] y);
        logic [63:0] m1, m2;
        m1 = {$urandom, $urandom};
        m2 = {$urandom, $urandom};
        return {m2, m1, y ^ m1 ^ m2};
    endfunction

    logic [191:0] pipe4 [4];
    logic [191:0] pipe2 [2];

    always @(posedge clk) begin
        pipe4[0] <= remask(sb_layer(sin4_0 ^ sin4_1 ^ sin4_2));
        for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
        pipe2[0] <= remask(sb_layer(sin2_0 ^ sin2_1 ^ sin2_2));
        pipe2[1] <= pipe2[0];
    end

    assign sout4_0 = pipe4[3][63:0];
    assign sout4_1 = pipe4[3][127:64];
    assign sout4_2 = pipe4[3][191:128];
    assign sout2_0 = pipe2[1][63:0];
    assign sout2_1 = pipe2[1][127:64];
    assign sout2_2 = pipe2[1][191:128];

    // Unmasked views of whichever DUT is selected.
    logic [63:0] ct_x, sin_x, ct_or, sin_or;
    logic        done_x, busy_x, act_x;
    assign ct_x   = sel2 ? (ct2_0 ^ ct2_1 ^ ct2_2) : (ct4_0 ^ ct4_1 ^ ct4_2);
    assign sin_x  = sel2 ? (sin2_0 ^ sin2_1 ^ sin2_2) : (sin4_0 ^ sin4_1 ^ sin4_2);
    assign ct_or  = sel2 ? (ct2_0 | ct2_1 | ct2_2) : (ct4_0 | ct4_1 | ct4_2);
    assign sin_or = sel2 ? (sin2_0 | sin2_1 | sin2_2) : (sin4_0 | sin4_1 | sin4_2);
    assign done_x = sel2 ? done2 : done4;
    assign busy_x = sel2 ? busy2 : busy4;
    assign act_x  = sel2 ? act2 : act4;

    // Unmasked Midori64 on a 16-cell array; cell 0 is the most significant nibble.
    function automatic logic [63:0] midori_ref(input logic [63:0] p, input logic [127:0] k);
        logic [3:0]  c [16];
        logic [3:0]  t [16];
        logic [3:0]  sum;
        logic [63:0] wk, rk, v;
        wk = k[127:64] ^ k[63:0];
        v  = p ^ wk;
        for (int i = 0; i < 16; i++) c[i] = v[63-4*i -: 4];
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < 16; i++) c[i] = SBX[c[i]];
            for (int i = 0; i < 16; i++) t[i] = c[PERM[i]];
            for (int col = 0; col < 4; col++) begin
                sum = t[4*col] ^ t[4*col+1] ^ t[4*col+2] ^ t[4*col+3];
                for (int j = 0; j < 4; j++) c[4*col+j] = sum ^ t[4*col+j];
            end
            rk = (r % 2 == 0) ? k[127:64] : k[63:0];
            for (int i = 0; i < 16; i++) c[i] = c[i] ^ rk[63-4*i -: 4] ^ {3'b000, BETA_T[r][15-i]};
        end
        for (int i = 0; i < 16; i++) c[i] = SBX[c[i]];
        for (int i = 0; i < 16; i++) v[63-4*i -: 4] = c[i];
        return v ^ wk;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present fresh random sharings of a plaintext and key.
    task automatic load(input logic [63:0] p, input logic [127:0] k);
        logic [63:0]  r1, r2;
        logic [127:0] q1, q2;
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        q1 = {$urandom, $urandom, $urandom, $urandom};
        q2 = {$urandom, $urandom, $urandom, $urandom};
        pt_s0  = p ^ r1 ^ r2;  pt_s1  = r1;  pt_s2  = r2;
        key_s0 = k ^ q1 ^ q2;  key_s1 = q1;  key_s2 = q2;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycles from the start-capturing edge until done is seen, bounded.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done_x !== 1'b1 && lat < 300) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_enc(input string tag, input logic [63:0] p, input logic [127:0] k, input int exp_lat);
        int lat;
        load(p, k);
        launch();
        check({tag, "/sbox_in"}, sin_x, p ^ k[127:64] ^ k[63:0]);
        check({tag, "/busy"}, 64'(busy_x), 64'd1);
        wait_done(lat);
        check({tag, "/lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "/ct"}, ct_x, midori_ref(p, k));
        tick();
        check({tag, "/done_pulse"}, 64'(done_x), 64'd0);
    endtask

    initial begin
        int          lat;
        int          nd;
        logic [63:0] p, p2, ct_prev;
        logic [127:0] k;

        repeat (3) tick();
        rst = 1'b0;
        check("rst/busy", 64'(busy4), 64'd0);
        check("rst/done", 64'(done4), 64'd0);
        check("rst/act", 64'(act4), 64'd0);
        check("rst/ct_or", ct_or, 64'd0);
        check("rst/sin_or", sin_or, 64'd0);
        check("rst/busy2", 64'(busy2), 64'd0);

        // Zero key and plaintext: known answer and cycle-exact latency.
        load(64'd0, 128'd0);
        launch();
        check("zero/act", 64'(act_x), 64'd1);
        check("zero/busy", 64'(busy_x), 64'd1);
        wait_done(lat);
        check("zero/lat", 64'(lat), 64'(LAT4));
        check("zero/ct", ct_x, CT_ZERO);
        tick();
        check("zero/done_pulse", 64'(done_x), 64'd0);
        check("zero/busy_after", 64'(busy_x), 64'd0);
        check("zero/act_after", 64'(act_x), 64'd0);

        // Published vector under many independent maskings.
        for (int i = 0; i < 100; i++) begin
            load(TV_PT, TV_KEY);
            launch();
            wait_done(lat);
            check("tv/ct", ct_x, TV_CT);
            tick();
        end

        // Random keys and plaintexts against the model.
        for (int i = 0; i < 12; i++) begin
            p = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            run_enc("rand", p, k, LAT4);
        end

        // Start pulses during an encryption are ignored.
        load(64'd0, 128'd0);
        launch();
        lat = 1;
        nd  = 0;
        while (done_x !== 1'b1 && lat < 300) begin
            start = (lat == 10 || lat == 40);
            if (lat == 10) pt_s0 = ~pt_s0;
            tick();
            start = 1'b0;
            lat++;
        end
        check("ignore/lat", 64'(lat), 64'(LAT4));
        check("ignore/ct", ct_x, CT_ZERO);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_x === 1'b1 || busy_x === 1'b1) nd++;
        end
        check("ignore/no_restart", 64'(nd), 64'd0);

        // Reset in the middle of an encryption.
        p = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        load(p, k);
        launch();
        lat = 1;
        while (lat < 30) begin
            tick();
            lat++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lat++;
        check("midrst/busy", 64'(busy_x), 64'd0);
        check("midrst/act", 64'(act_x), 64'd0);
        check("midrst/done", 64'(done_x), 64'd0);
        check("midrst/ct_or", ct_or, 64'd0);
        check("midrst/sin_or", sin_or, 64'd0);
        nd = 0;
        while (lat < 35) begin
            tick();
            lat++;
            if (done_x === 1'b1) nd++;
        end
        check("midrst/no_done", 64'(nd), 64'd0);
        run_enc("midrst/restart", p, k, LAT4);

        // Back-to-back: start during DONE ignored, start the next cycle accepted.
        p = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        load(p, k);
        launch();
        wait_done(lat);
        check("b2b/lat1", 64'(lat), 64'(LAT4));
        ct_prev = midori_ref(p, k);
        check("b2b/ct1", ct_x, ct_prev);
        load(~p, k);
        start = 1'b1;
        tick();
        check("b2b/done_ignored", 64'(busy_x), 64'd0);
        check("b2b/held1", ct_x, ct_prev);
        p2 = {$urandom, $urandom};
        load(p2, k);
        check("b2b/held2", ct_x, ct_prev);
        tick();
        start = 1'b0;
        check("b2b/accepted", 64'(busy_x), 64'd1);
        check("b2b/sbox_in", sin_x, p2 ^ k[127:64] ^ k[63:0]);
        wait_done(lat);
        check("b2b/lat2", 64'(lat), 64'(LAT4));
        check("b2b/ct2", ct_x, midori_ref(p2, k));
        tick();

        // Two-cycle S-box build.
        sel2 = 1'b1;
        tick();
        run_enc("lat2/zero", 64'd0, 128'd0, LAT2);
        check("lat2/zero_kat", ct_x, CT_ZERO);
        run_enc("lat2/tv", TV_PT, TV_KEY, LAT2);
        for (int i = 0; i < 6; i++) begin
            p = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            run_enc("lat2/rand", p, k, LAT2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
